// File: rtl/apb_arb_pkg.sv
// Shared definitions for the two-requester APB master arbiter.
//   - FSM state encoding (IDLE / SETUP / ACCESS)
//   - default bus widths, requester count and ACCESS watchdog limit
// The watchdog itself is only built when APB_ARB_TIMEOUT_EN is defined.
package apb_arb_pkg;

    localparam int unsigned ADDR_W_DEF         = 32;
    localparam int unsigned DATA_W_DEF         = 32;
    localparam int unsigned NUM_REQ            = 2;
    localparam int unsigned TIMEOUT_CYCLES_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Two-way round-robin grant generator.
// Ports:
//   PCLK, PRESETn   clock / async active-low reset
//   valid_i[1:0]    pending requests
//   advance_i       a grant was taken this cycle; remember who won
//   grant_o[1:0]    one-hot grant (combinational from valid_i and history)
// After reset requester 0 wins a tie.
module apb_rr_arbiter
    import apb_arb_pkg::*;
(
    input  logic               PCLK,
    input  logic               PRESETn,
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic               advance_i,
    output logic [NUM_REQ-1:0] grant_o
);

    // Index of the requester granted last. Resetting it to 1 makes
    // requester 0 the first winner of a tie.
    logic last_q;
    logic last_d;

    always_comb begin
        grant_o = '0;
        case (valid_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_q ? 2'b01 : 2'b10;
            default: grant_o = '0;
        endcase
    end

    always_comb begin
        last_d = last_q;
        if (advance_i && (grant_o != '0)) begin
            last_d = grant_o[1];
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Two-requester APB master: arbitrates round-robin between req0/req1 and
// runs one APB transfer at a time (IDLE -> SETUP -> ACCESS -> IDLE).
// Ports:
//   PCLK, PRESETn                  clock / async active-low reset
//   reqN_valid/write/addr/wdata    request side, reqN_ready grant pulse
//   rspN_valid/rdata/err           one-cycle completion, no backpressure
//   PSELx/PENABLE/PWRITE/PADDR/PWDATA, PRDATA/PREADY/PSLVERR   APB bus
// Build option:
//   APB_ARB_TIMEOUT_EN  adds an ACCESS watchdog that ends a transfer with
//                       err=1 after TIMEOUT_CYCLES wait cycles.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | bus idle, address/data driven 0, grant a pending request
// ST_SETUP  | PSELx=1, PENABLE=0, latched transfer on the bus
// ST_ACCESS | PSELx=1, PENABLE=1, wait for PREADY (or watchdog)
module apb_master_arbiter
    import apb_arb_pkg::*;
#(
    parameter int unsigned ADDR_W         = ADDR_W_DEF,
    parameter int unsigned DATA_W         = DATA_W_DEF,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic              PCLK,
    input  logic              PRESETn,

    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp0_err,

    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              rsp1_err,

    output logic              PSELx,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    apb_state_e          state_q, state_d;
    logic                sel_q, sel_d;        // granted requester index
    logic                psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    // Low from reset until the first clock after release, so that ready
    // stays 0 while PRESETn is low regardless of reqN_valid.
    logic                run_q;

    logic [NUM_REQ-1:0]  req_valid;
    logic [NUM_REQ-1:0]  gnt;
    logic                accept;
    logic                xfer_done;

`ifdef APB_ARB_TIMEOUT_EN
    // Counts completed wait cycles in ACCESS; the wait cycle that would
    // bring it to TIMEOUT_CYCLES ends the transfer instead.
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
`endif

    assign req_valid = {req1_valid, req0_valid};
    assign accept    = run_q && (state_q == ST_IDLE) && (|req_valid);

    apb_rr_arbiter u_rr (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .valid_i   (req_valid),
        .advance_i (accept),
        .grant_o   (gnt)
    );

    assign req0_ready = accept & gnt[0];
    assign req1_ready = accept & gnt[1];

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = '0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        xfer_done   = 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    sel_d    = gnt[1];
                    pwrite_d = gnt[1] ? req1_write : req0_write;
                    paddr_d  = gnt[1] ? req1_addr  : req0_addr;
                    pwdata_d = gnt[1] ? req1_wdata : req0_wdata;
                    psel_d   = 1'b1;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                state_d   = ST_ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end
            ST_ACCESS: begin
                // PREADY is checked first so a completion on the limit
                // cycle wins over the watchdog.
                if (PREADY) begin
                    xfer_done   = 1'b1;
                    rsp_err_d   = PSLVERR;
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
                end
`ifdef APB_ARB_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    xfer_done = 1'b1;
                    rsp_err_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                end
`endif
                if (xfer_done) begin
                    state_d            = ST_IDLE;
                    psel_d             = 1'b0;
                    penable_d          = 1'b0;
                    pwrite_d           = 1'b0;
                    paddr_d            = '0;
                    pwdata_d           = '0;
                    rsp_valid_d[sel_q] = 1'b1;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                psel_d    = 1'b0;
                penable_d = 1'b0;
                pwrite_d  = 1'b0;
                paddr_d   = '0;
                pwdata_d  = '0;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= ST_IDLE;
            sel_q       <= 1'b0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            run_q       <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
            tmo_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            run_q       <= 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
`endif
        end
    end

    assign PSELx   = psel_q;
    assign PENABLE = penable_q;
    assign PWRITE  = pwrite_q;
    assign PADDR   = paddr_q;
    assign PWDATA  = pwdata_q;

    // Response payload is shared; each port only sees it while its own
    // valid is high.
    assign rsp0_valid = rsp_valid_q[0];
    assign rsp1_valid = rsp_valid_q[1];
    assign rsp0_rdata = rsp_valid_q[0] ? rsp_rdata_q : '0;
    assign rsp1_rdata = rsp_valid_q[1] ? rsp_rdata_q : '0;
    assign rsp0_err   = rsp_valid_q[0] & rsp_err_q;
    assign rsp1_err   = rsp_valid_q[1] & rsp_err_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
`timescale 1ns/1ps
module tb_apb_master_arbiter;

    localparam int TMO = 16;

    logic              PCLK = 1'b0;
    logic              PRESETn = 1'b0;
    logic [1:0]        req_valid, req_write;
    logic [1:0][31:0]  req_addr, req_wdata;
    wire  [1:0]        req_ready, rsp_valid, rsp_err;
    wire  [1:0][31:0]  rsp_rdata;
    wire               PSELx, PENABLE, PWRITE;
    wire  [31:0]       PADDR, PWDATA;
    logic [31:0]       PRDATA;
    logic              PREADY, PSLVERR;

    apb_master_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TMO)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req0_valid(req_valid[0]), .req0_write(req_write[0]), .req0_addr(req_addr[0]),
        .req0_wdata(req_wdata[0]), .req0_ready(req_ready[0]), .rsp0_valid(rsp_valid[0]),
        .rsp0_rdata(rsp_rdata[0]), .rsp0_err(rsp_err[0]),
        .req1_valid(req_valid[1]), .req1_write(req_write[1]), .req1_addr(req_addr[1]),
        .req1_wdata(req_wdata[1]), .req1_ready(req_ready[1]), .rsp1_valid(rsp_valid[1]),
        .rsp1_rdata(rsp_rdata[1]), .rsp1_err(rsp_err[1]),
        .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    wire any_out = PSELx | PENABLE | PWRITE | (|PADDR) | (|PWDATA) | (|req_ready)
                 | (|rsp_valid) | (|rsp_err) | (|rsp_rdata);

    typedef struct {
        int          port;
        logic [31:0] rdata;
        logic        err;
        int          cyc;      // -1: completion time not predicted
    } exp_t;

    exp_t        sb[$];
    int          gnt_log[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          slv_wait = 0;
    logic [31:0] slv_prdata = '0;
    logic        slv_err = 1'b0;

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    initial forever #5 PCLK = ~PCLK;
    initial forever begin @(posedge PCLK); cyc++; end

    // APB slave: PREADY rises after slv_wait low ACCESS cycles.
    initial begin
        int acc_cnt;
        acc_cnt = 0;
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
        forever begin
            @(negedge PCLK);
            if (PSELx && PENABLE) begin
                PREADY = (acc_cnt >= slv_wait);
                acc_cnt++;
            end else begin
                PREADY = 1'b0;
                acc_cnt = 0;
            end
            PRDATA  = slv_prdata;
            PSLVERR = slv_err;
        end
    end

    // Monitor: round-robin model, bus checks and scoreboard.
    initial begin
        int          model_last, exp_p, p, acc_cyc;
        logic        prev_pen, cur_write;
        logic [31:0] cur_addr, cur_wdata;
        exp_t        e;
        model_last = 1; acc_cyc = 0; prev_pen = 1'b0;
        cur_addr = '0; cur_wdata = '0; cur_write = 1'b0;
        forever begin
            @(negedge PCLK);
            if (!PRESETn) begin
                model_last = 1;
                prev_pen = 1'b0;
            end else begin
                if (req_ready[0] && req_ready[1]) check_val("ready_onehot", req_ready, 2'b01);
                else if (req_ready != 2'b00) begin
                    if (req_valid == 2'b11) exp_p = (model_last == 0) ? 1 : 0;
                    else exp_p = req_valid[1] ? 1 : 0;
                    check_val("grant", req_ready[1] ? 1 : 0, exp_p);
                    check_val("ready_idle", PSELx, 0);
                    model_last = exp_p;
                    gnt_log.push_back(exp_p);
                    acc_cyc   = cyc;
                    cur_addr  = req_addr[exp_p];
                    cur_wdata = req_wdata[exp_p];
                    cur_write = req_write[exp_p];
                    e.port  = exp_p;
                    e.err   = slv_err;
                    e.rdata = req_write[exp_p] ? 32'h0 : slv_prdata;
                    e.cyc   = (slv_wait >= 1000) ? -1 : cyc + 3 + slv_wait;
`ifdef APB_ARB_TIMEOUT_EN
                    if (slv_wait >= TMO) begin
                        e.err = 1'b1; e.rdata = '0; e.cyc = cyc + 2 + TMO;
                    end
`endif
                    sb.push_back(e);
                end
                if (PSELx) begin
                    check_val("paddr", PADDR, cur_addr);
                    check_val("pwdata", PWDATA, cur_wdata);
                    check_val("pwrite", PWRITE, cur_write);
                    if (!PENABLE) check_val("setup_lat", cyc, acc_cyc + 1);
                    else if (!prev_pen) check_val("access_lat", cyc, acc_cyc + 2);
                end else begin
                    check_val("idle_bus", PENABLE | PWRITE | (|PADDR) | (|PWDATA), 0);
                end
                if (rsp_valid == 2'b11) check_val("rsp_overlap", rsp_valid, 2'b01);
                else if (rsp_valid != 2'b00) begin
                    p = rsp_valid[1] ? 1 : 0;
                    if (sb.size() == 0) check_val("rsp_unexpected", rsp_valid, 0);
                    else begin
                        e = sb.pop_front();
                        check_val("rsp_port", p, e.port);
                        check_val("rsp_rdata", rsp_rdata[p], e.rdata);
                        check_val("rsp_err", rsp_err[p], e.err);
                        if (e.cyc >= 0) check_val("rsp_lat", cyc, e.cyc);
                    end
                end
                if (!rsp_valid[0]) check_val("rsp0_quiet", {rsp_err[0], rsp_rdata[0]}, 0);
                if (!rsp_valid[1]) check_val("rsp1_quiet", {rsp_err[1], rsp_rdata[1]}, 0);
                prev_pen = PENABLE;
            end
        end
    end

    task automatic do_req(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
        int n;
        n = 0;
        req_valid[p] = 1'b1; req_write[p] = w; req_addr[p] = a; req_wdata[p] = d;
        forever begin
            @(negedge PCLK);
            if (req_ready[p]) break;
            n++;
            if (n > 300) begin
                check_val("req_timeout", 1, 0);
                break;
            end
        end
        @(posedge PCLK); #1;
        req_valid[p] = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge PCLK);
            n++;
        end while ((sb.size() != 0 || PSELx) && n < 500);
        if (n >= 500) check_val("idle_timeout", 1, 0);
        @(posedge PCLK); #1;
    endtask

    task automatic wait_access();
        int n;
        n = 0;
        do begin
            @(negedge PCLK);
            n++;
        end while (!PENABLE && n < 100);
        if (n >= 100) check_val("access_timeout", 1, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge PCLK);
        #1;
        check_val("rst_outputs", any_out, 0);
        PRESETn = 1'b1;
        @(posedge PCLK); #1;

        // single write, zero wait states
        slv_wait = 0; slv_prdata = 32'hFFFF_0000;
        do_req(0, 1'b1, 32'h0000_0010, 32'hA5A5_A5A5);
        wait_idle();

        // read with three wait states
        slv_wait = 3; slv_prdata = 32'h1234_5678;
        do_req(1, 1'b0, 32'h0000_0004, 32'h0);
        wait_idle();

        // both held valid: alternating grants
        slv_wait = 0; slv_prdata = 32'hCAFE_0001;
        gnt_log.delete();
        fork
            begin
                do_req(0, 1'b1, 32'h100, 32'h1111_0001);
                do_req(0, 1'b0, 32'h104, 32'h0);
            end
            begin
                do_req(1, 1'b0, 32'h200, 32'h0);
                do_req(1, 1'b1, 32'h204, 32'h2222_0002);
            end
        join
        wait_idle();
        check_val("rr_count", gnt_log.size(), 4);
        for (int i = 0; i < 4 && i < gnt_log.size(); i++)
            check_val("rr_order", gnt_log[i], i % 2);

        // slave error, then a clean read
        slv_err = 1'b1;
        do_req(0, 1'b1, 32'h30, 32'hDEAD_BEEF);
        wait_idle();
        slv_err = 1'b0; slv_prdata = 32'h0BAD_F00D;
        do_req(0, 1'b0, 32'h34, 32'h0);
        wait_idle();

        // reset in ACCESS: outputs drop at once, transfer is lost, req0 first
        slv_wait = 1000;
        do_req(0, 1'b1, 32'h40, 32'h7777_7777);
        wait_access();
        @(posedge PCLK); #3;
        PRESETn = 1'b0;
        #1;
        check_val("rst_async", any_out, 0);
        sb.delete();
        repeat (2) @(posedge PCLK);
        #1;
        check_val("rst_hold", any_out, 0);
        slv_wait = 0; slv_prdata = 32'h5A5A_0003;
        gnt_log.delete();
        fork
            do_req(0, 1'b0, 32'h80, 32'h0);
            do_req(1, 1'b1, 32'h84, 32'h3333_0003);
            begin #2; PRESETn = 1'b1; end
        join
        wait_idle();
        check_val("rst_rr_first", (gnt_log.size() > 0) ? gnt_log[0] : 9, 0);

        // stalled slave
        slv_wait = 1000; slv_prdata = 32'h600D_0001;
        do_req(1, 1'b0, 32'h50, 32'h0);
`ifdef APB_ARB_TIMEOUT_EN
        wait_idle();
`else
        wait_access();
        repeat (100) @(negedge PCLK);
        check_val("hold_access", {PSELx, PENABLE}, 2'b11);
        check_val("hold_no_rsp", sb.size(), 1);
        slv_wait = 0;
        wait_idle();
`endif

        repeat (3) @(posedge PCLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
